// File: rtl/cache_controller_param.sv
// 2-way set-associative write-through, no-write-allocate data cache controller with
// write-update, critical-word forwarding and global flush. Optional CACHE_STATS_EN adds hit/miss counters.
module cache_controller_param #(
    parameter int INDEX_BITS = 6,
    parameter int LINE_WORDS = 2,
    parameter int TAG_BITS   = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              address,
    input  logic [31:0]              wdata,
    input  logic                     MEM_R_EN,
    input  logic                     MEM_W_EN,
    input  logic                     flush,
    output logic [31:0]              rdata,
    output logic                     ready,
    output logic [31:0]              sram_address,
    output logic [31:0]              sram_wdata,
    output logic                     sram_read,
    output logic                     sram_write,
    input  logic [32*LINE_WORDS-1:0] sram_rdata,
    input  logic                     sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count,
    input  logic                     stats_clr
`endif
);

    localparam int OFF_BITS  = $clog2(LINE_WORDS);
    localparam int SETS      = 1 << INDEX_BITS;
    localparam int LINE_W    = 32 * LINE_WORDS;
    localparam int ADDR_USED = 2 + OFF_BITS + INDEX_BITS + TAG_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [LINE_W-1:0]   data0_q [SETS];
    logic [LINE_W-1:0]   data1_q [SETS];
    logic [TAG_BITS-1:0] tag0_q  [SETS];
    logic [TAG_BITS-1:0] tag1_q  [SETS];
    logic [SETS-1:0]     valid0_q;
    logic [SETS-1:0]     valid1_q;
    logic [SETS-1:0]     lru_q;

    logic [OFF_BITS-1:0]   offset_w;
    logic [INDEX_BITS-1:0] index_w;
    logic [TAG_BITS-1:0]   tag_w;
    logic                  hit0, hit1, hit, hit_way, victim_way;
    logic [LINE_W-1:0]     hit_line;
    logic [31:0]           hit_word, fill_word;
    logic                  flush_en, fill_en, upd_en, rd_hit_en;
    logic                  unused_addr_bits;

    assign offset_w = address[2 +: OFF_BITS];
    assign index_w  = address[2 + OFF_BITS +: INDEX_BITS];
    assign tag_w    = address[2 + OFF_BITS + INDEX_BITS +: TAG_BITS];
    assign unused_addr_bits = ^{address[1:0], address >> ADDR_USED};

    assign sram_address = address;
    assign sram_wdata   = wdata;

    assign hit0    = valid0_q[index_w] && (tag0_q[index_w] == tag_w);
    assign hit1    = valid1_q[index_w] && (tag1_q[index_w] == tag_w);
    assign hit     = hit0 || hit1;
    assign hit_way = hit1;
    // Fill an empty way first; only when both are live does LRU pick the victim.
    assign victim_way = !valid0_q[index_w] ? 1'b0 :
                        !valid1_q[index_w] ? 1'b1 : lru_q[index_w];
    assign hit_line = hit_way ? data1_q[index_w] : data0_q[index_w];

    always_comb begin
        hit_word  = '0;
        fill_word = '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            if (offset_w == k[OFF_BITS-1:0]) begin
                hit_word  = hit_line[32*k +: 32];
                fill_word = sram_rdata[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        ready      = 1'b0;
        rdata      = '0;
        sram_read  = 1'b0;
        sram_write = 1'b0;
        flush_en   = 1'b0;
        fill_en    = 1'b0;
        upd_en     = 1'b0;
        rd_hit_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    flush_en = 1'b1;
                end else if (MEM_W_EN) begin
                    state_d = S_WRITE;
                end else if (MEM_R_EN) begin
                    if (hit) begin
                        ready     = 1'b1;
                        rdata     = hit_word;
                        rd_hit_en = 1'b1;
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            S_READ: begin
                sram_read = 1'b1;
                if (sram_ready) begin
                    fill_en = 1'b1;
                    ready   = 1'b1;
                    rdata   = fill_word;
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                sram_write = 1'b1;
                if (sram_ready) begin
                    ready   = 1'b1;
                    upd_en  = hit;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
            for (int s = 0; s < SETS; s++) begin
                data0_q[s] <= '0;
                data1_q[s] <= '0;
                tag0_q[s]  <= '0;
                tag1_q[s]  <= '0;
            end
        end else begin
            if (flush_en) begin
                valid0_q <= '0;
                valid1_q <= '0;
            end
            if (fill_en) begin
                if (victim_way) begin
                    data1_q[index_w]  <= sram_rdata;
                    tag1_q[index_w]   <= tag_w;
                    valid1_q[index_w] <= 1'b1;
                end else begin
                    data0_q[index_w]  <= sram_rdata;
                    tag0_q[index_w]   <= tag_w;
                    valid0_q[index_w] <= 1'b1;
                end
                lru_q[index_w] <= ~victim_way;
            end
            // Store hit patches the resident word so the line stays valid.
            if (upd_en) begin
                for (int k = 0; k < LINE_WORDS; k++) begin
                    if (offset_w == k[OFF_BITS-1:0]) begin
                        if (hit_way) data1_q[index_w][32*k +: 32] <= wdata;
                        else         data0_q[index_w][32*k +: 32] <= wdata;
                    end
                end
                lru_q[index_w] <= ~hit_way;
            end
            if (rd_hit_en) lru_q[index_w] <= ~hit_way;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        hit_inc, miss_inc;

    assign hit_inc  = rd_hit_en;
    assign miss_inc = (state_q == S_IDLE) && (state_d == S_READ);

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_inc && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_inc && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_controller_param.sv
// Self-checking bench for cache_controller_param (default parameters, 64-bit lines).
module tb_cache_controller_param;

  logic        clk, rst;
  logic [31:0] address, wdata;
  logic        MEM_R_EN, MEM_W_EN, flush;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address, sram_wdata;
  logic        sram_read, sram_write;
  logic [63:0] sram_rdata;
  logic        sram_ready;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
  logic        stats_clr;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  bit          hit, frdy, erdy, drdy;
  logic [31:0] got;
  int          cyc;

  cache_controller_param dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .flush(flush),
    .rdata(rdata), .ready(ready), .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_read(sram_read), .sram_write(sram_write), .sram_rdata(sram_rdata),
    .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .stats_clr(stats_clr)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; flush = 1'b0;
    sram_ready = 1'b0; sram_rdata = '0; address = '0; wdata = '0;
`ifdef CACHE_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [63:0] mk_line(input logic [31:0] a);
    return {a ^ 32'hC0DE_0004, a ^ 32'hC0DE_0000};
  endfunction

  // driver: load request; a miss is served after lat cycles of sram_read
  task automatic drive_read(input logic [31:0] a, input logic [63:0] line, input int lat,
                            output bit h, output bit fr, output logic [31:0] d, output int rc);
    @(negedge clk);
    address = a; MEM_R_EN = 1'b1;
    #1;
    rc = 0; fr = 1'b0;
    if (ready === 1'b1) begin
      h = 1'b1; d = rdata;
      if (sram_read !== 1'b0) rc = 1;
      @(posedge clk); #1 MEM_R_EN = 1'b0;
    end else begin
      h = 1'b0;
      @(posedge clk);
      repeat (lat) begin
        @(negedge clk); #1;
        if (sram_read === 1'b1) rc++;
      end
      @(negedge clk);
      sram_ready = 1'b1; sram_rdata = line;
      #1 fr = ready; d = rdata;
      @(posedge clk); #1 sram_ready = 1'b0; MEM_R_EN = 1'b0;
    end
  endtask

  // driver: store request; sram_write counted over the whole access
  task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input int lat,
                             output bit er, output bit dr, output int wc);
    @(negedge clk);
    address = a; wdata = d; MEM_W_EN = 1'b1;
    #1 er = ready;
    @(posedge clk);
    wc = 0;
    repeat (lat) begin
      @(negedge clk); #1;
      if (sram_write === 1'b1) wc++;
    end
    @(negedge clk);
    sram_ready = 1'b1;
    #1 dr = ready;
    if (sram_write === 1'b1) wc++;
    @(posedge clk); #1 sram_ready = 1'b0; MEM_W_EN = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", ready); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    checks++; if (sram_read !== 1'b0) begin errors++; $display("FAIL rst_sram_read got=%b exp=0", sram_read); end
    checks++; if (sram_write !== 1'b0) begin errors++; $display("FAIL rst_sram_write got=%b exp=0", sram_write); end
    sram_ready = 1'b1;
    @(posedge clk); #1 sram_ready = 1'b0;
    @(negedge clk); #1;
    checks++; if (ready !== 1'b1 || sram_read !== 1'b0) begin errors++; $display("FAIL idle_sram_ready_ignored got=%b%b exp=10", ready, sram_read); end
  endtask

  task automatic test_read_miss_fill();
    do_reset();
    exp_q.push_back(32'hAAAA_AAAA);
    drive_read(32'h40, 64'hBBBB_BBBB_AAAA_AAAA, 3, hit, frdy, got, cyc);
    exp_w = exp_q.pop_front();
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_040 got=%b exp=0", hit); end
    checks++; if (cyc !== 3) begin errors++; $display("FAIL sram_read_cycles got=%0d exp=3", cyc); end
    checks++; if (frdy !== 1'b1) begin errors++; $display("FAIL fill_ready got=%b exp=1", frdy); end
    checks++; if (got !== exp_w) begin errors++; $display("FAIL fill_forward got=%h exp=%h", got, exp_w); end
    exp_q.push_back(32'hBBBB_BBBB);
    drive_read(32'h44, '0, 3, hit, frdy, got, cyc);
    exp_w = exp_q.pop_front();
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_044 got=%b exp=1", hit); end
    checks++; if (got !== exp_w) begin errors++; $display("FAIL hit_044_data got=%h exp=%h", got, exp_w); end
    checks++; if (cyc !== 0) begin errors++; $display("FAIL hit_no_sram_read got=%0d exp=0", cyc); end
  endtask

  // second_reread picks which line is touched before the third fill
  task automatic test_lru(input logic [31:0] reread, input logic [31:0] survivor, input logic [31:0] victim);
    do_reset();
    drive_read(32'h040, mk_line(32'h040), 1, hit, frdy, got, cyc);
    drive_read(32'h240, mk_line(32'h240), 1, hit, frdy, got, cyc);
    exp_q.push_back(mk_line(reread)[31:0]);
    drive_read(reread, '0, 1, hit, frdy, got, cyc);
    exp_w = exp_q.pop_front();
    checks++; if (hit !== 1'b1 || got !== exp_w) begin errors++; $display("FAIL lru_reread_%h got=%b/%h exp=1/%h", reread, hit, got, exp_w); end
    drive_read(32'h440, mk_line(32'h440), 1, hit, frdy, got, cyc);
    exp_q.push_back(mk_line(survivor)[31:0]);
    drive_read(survivor, '0, 1, hit, frdy, got, cyc);
    exp_w = exp_q.pop_front();
    checks++; if (hit !== 1'b1 || got !== exp_w) begin errors++; $display("FAIL lru_survivor_%h got=%b/%h exp=1/%h", survivor, hit, got, exp_w); end
    drive_read(victim, mk_line(victim), 1, hit, frdy, got, cyc);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL lru_victim_%h got=%b exp=0", victim, hit); end
  endtask

  task automatic test_write_hit();
    do_reset();
    drive_read(32'h40, 64'hBBBB_BBBB_AAAA_AAAA, 2, hit, frdy, got, cyc);
    drive_write(32'h44, 32'h1234_5678, 3, erdy, drdy, cyc);
    checks++; if (erdy !== 1'b0) begin errors++; $display("FAIL wr_early_ready got=%b exp=0", erdy); end
    checks++; if (cyc !== 4) begin errors++; $display("FAIL wr_sram_write_cycles got=%0d exp=4", cyc); end
    checks++; if (drdy !== 1'b1) begin errors++; $display("FAIL wr_done_ready got=%b exp=1", drdy); end
    exp_q.push_back(32'h1234_5678);
    drive_read(32'h44, '0, 2, hit, frdy, got, cyc);
    exp_w = exp_q.pop_front();
    checks++; if (hit !== 1'b1 || cyc !== 0) begin errors++; $display("FAIL wr_update_hit got=%b/%0d exp=1/0", hit, cyc); end
    checks++; if (got !== exp_w) begin errors++; $display("FAIL wr_update_data got=%h exp=%h", got, exp_w); end
    exp_q.push_back(32'hAAAA_AAAA);
    drive_read(32'h40, '0, 2, hit, frdy, got, cyc);
    exp_w = exp_q.pop_front();
    checks++; if (hit !== 1'b1 || got !== exp_w) begin errors++; $display("FAIL wr_other_word got=%b/%h exp=1/%h", hit, got, exp_w); end
  endtask

  task automatic test_write_miss();
    do_reset();
    drive_write(32'h800, 32'hFACE_0001, 2, erdy, drdy, cyc);
    checks++; if (drdy !== 1'b1 || cyc !== 3) begin errors++; $display("FAIL wr_miss_done got=%b/%0d exp=1/3", drdy, cyc); end
    drive_read(32'h800, mk_line(32'h800), 1, hit, frdy, got, cyc);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL no_allocate got=%b exp=0", hit); end
  endtask

  task automatic test_flush();
    do_reset();
    drive_read(32'h40, mk_line(32'h40), 1, hit, frdy, got, cyc);
    @(negedge clk);
    address = 32'h40; MEM_R_EN = 1'b1; flush = 1'b1;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", ready); end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk); #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL post_flush_miss got=%b exp=0", ready); end
    @(posedge clk);
    @(negedge clk); #1;
    checks++; if (sram_read !== 1'b1) begin errors++; $display("FAIL post_flush_sram_read got=%b exp=1", sram_read); end
    exp_q.push_back(32'h0BAD_F00D);
    sram_ready = 1'b1; sram_rdata = {32'h1, 32'h0BAD_F00D};
    #1 exp_w = exp_q.pop_front();
    checks++; if (ready !== 1'b1 || rdata !== exp_w) begin errors++; $display("FAIL post_flush_fill got=%b/%h exp=1/%h", ready, rdata, exp_w); end
    @(posedge clk); #1 sram_ready = 1'b0; MEM_R_EN = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    drive_read(32'h40, mk_line(32'h40), 1, hit, frdy, got, cyc);
    @(negedge clk);
    address = 32'h840; MEM_R_EN = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    checks++; if (sram_read !== 1'b1) begin errors++; $display("FAIL mid_read_active got=%b exp=1", sram_read); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; MEM_R_EN = 1'b0;
    @(negedge clk); #1;
    checks++; if (sram_read !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL mid_reset_abort got=%b%b exp=01", sram_read, ready); end
    drive_read(32'h44, mk_line(32'h40), 1, hit, frdy, got, cyc);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL mid_reset_cleared got=%b exp=0", hit); end
  endtask

  // randomized traffic on one set against a reference model of the replacement policy
  task automatic test_back_to_back();
    logic        m_valid[2];
    logic [1:0]  m_tag[2];
    logic [63:0] m_line[2];
    logic        m_lru, w, mh;
    logic [31:0] a, d;
    logic [1:0]  t;
    int          off, lat;
    do_reset();
    m_valid[0] = 0; m_valid[1] = 0; m_tag[0] = 0; m_tag[1] = 0; m_lru = 0;
    m_line[0] = '0; m_line[1] = '0;
    for (int i = 0; i < 40; i++) begin
      t = 2'($urandom_range(0, 2));
      off = $urandom_range(0, 1);
      lat = $urandom_range(0, 3);
      a = {21'd0, t, 6'd5, 3'd0} | (off << 2);
      mh = 0; w = 0;
      for (int k = 0; k < 2; k++) if (m_valid[k] && m_tag[k] == t) begin mh = 1; w = k[0]; end
      if ($urandom_range(0, 3) == 0) begin
        d = $urandom;
        drive_write(a, d, lat, erdy, drdy, cyc);
        checks++; if (drdy !== 1'b1 || cyc !== lat + 1) begin errors++; $display("FAIL rnd_write_%0d got=%b/%0d exp=1/%0d", i, drdy, cyc, lat + 1); end
        if (mh) begin
          if (off == 0) m_line[w][31:0] = d; else m_line[w][63:32] = d;
          m_lru = ~w;
        end
      end else begin
        if (mh) exp_q.push_back(off == 0 ? m_line[w][31:0] : m_line[w][63:32]);
        else    exp_q.push_back(off == 0 ? mk_line(a)[31:0] : mk_line(a)[63:32]);
        drive_read(a, mk_line(a), lat, hit, frdy, got, cyc);
        exp_w = exp_q.pop_front();
        checks++; if (hit !== mh || got !== exp_w) begin errors++; $display("FAIL rnd_read_%0d got=%b/%h exp=%b/%h", i, hit, got, mh, exp_w); end
        if (mh) m_lru = ~w;
        else begin
          w = !m_valid[0] ? 1'b0 : !m_valid[1] ? 1'b1 : m_lru;
          m_valid[w] = 1; m_tag[w] = t; m_line[w] = mk_line(a); m_lru = ~w;
        end
      end
    end
  endtask

`ifdef CACHE_STATS_EN
  task automatic test_stats();
    do_reset();
    drive_read(32'h40, mk_line(32'h40), 1, hit, frdy, got, cyc);
    drive_read(32'h40, '0, 1, hit, frdy, got, cyc);
    drive_read(32'h44, '0, 1, hit, frdy, got, cyc);
    @(negedge clk); #1;
    checks++; if (hit_count !== 32'd2) begin errors++; $display("FAIL stats_hits got=%0d exp=2", hit_count); end
    checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL stats_misses got=%0d exp=1", miss_count); end
    stats_clr = 1'b1;
    @(posedge clk); #1 stats_clr = 1'b0;
    @(negedge clk); #1;
    checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL stats_clear got=%0d/%0d exp=0/0", hit_count, miss_count); end
  endtask
`endif

  initial begin
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; flush = 1'b0;
    address = '0; wdata = '0; sram_rdata = '0; sram_ready = 1'b0;
`ifdef CACHE_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_read_miss_fill();
    test_lru(32'h240, 32'h240, 32'h040);
    test_lru(32'h040, 32'h040, 32'h240);
    test_write_hit();
    test_write_miss();
    test_flush();
    test_reset_mid_read();
    test_back_to_back();
`ifdef CACHE_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_controller_param.md
Name: cache_controller_param

Overview:
- Parametrised successor to the MEM-stage data cache controller: 2-way set-associative, write-through, no-write-allocate.
- Generalised in set count, line length and tag width. Adds three behaviours: write-update on write hit, critical-word forwarding on read-miss fill, and a global flush.
- Sits between the MEM stage and the SRAM controller. The SRAM controller returns one full line per sram_ready.

Parameters:
- INDEX_BITS, 6, log2 of number of sets.
- LINE_WORDS, 2, 32-bit words per line; power of two, at least 2. OFF_BITS = log2(LINE_WORDS).
- TAG_BITS, 10, stored tag width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- address  in  32  byte address from MEM stage
- wdata  in  32  store data
- MEM_R_EN  in  1  load request
- MEM_W_EN  in  1  store request
- flush  in  1  invalidate all lines
- rdata  out  32  load data
- ready  out  1  request complete / pipeline may advance
- sram_address  out  32  equals address
- sram_wdata  out  32  equals wdata
- sram_read  out  1  line read request
- sram_write  out  1  word write request
- sram_rdata  in  32*LINE_WORDS  line data; word k at bits [32k+31:32k]
- sram_ready  in  1  SRAM access done, single-cycle pulse

Behaviour:
- Address split:
  - offset = address[2 +: OFF_BITS]
  - index = address[2+OFF_BITS +: INDEX_BITS]
  - tag = address[2+OFF_BITS+INDEX_BITS +: TAG_BITS]
  - Higher bits are ignored.
- Per set state: 2 ways of data, tag and valid, plus one LRU bit. LRU names the way to replace next.
- hitN = validN[index] && tagN[index]==tag. Both ways can never hit at once.
- Victim way:
  - the first invalid way, way0 before way1;
  - otherwise the way named by LRU.
- Any hit or fill on way N sets LRU to the other way.
- FSM states: IDLE, READ, WRITE. Transitions are registered; outputs are combinational from state and inputs.
- IDLE:
  - flush=1 has priority. ready=0; all valid bits clear at the clock edge. A request presented in the same cycle is deferred: it is not started and must be held.
  - MEM_W_EN=1 (takes priority over MEM_R_EN) -> go to WRITE, ready=0.
  - MEM_R_EN hit -> ready=1, rdata = hit word at offset (zero-latency), LRU updated.
  - MEM_R_EN miss -> go to READ, ready=0.
  - No request -> ready=1.
- READ:
  - sram_read=1 until sram_ready.
  - On the sram_ready cycle: victim way gets line, tag, valid=1 and LRU is updated; ready=1; rdata = word `offset` of sram_rdata (forwarded, not read from the array); next state IDLE.
- WRITE:
  - sram_write=1 until sram_ready.
  - On the sram_ready cycle: ready=1 and next state IDLE.
  - If the store hits, the hit way's word at offset is overwritten with wdata and LRU is updated. The line stays valid (write-update, not invalidate).
  - On a miss the cache is unchanged.
- Hit/miss evaluation in WRITE uses the current address. The MEM stage holds address, wdata and the enables stable until ready.
- rdata in all cases other than a read hit or the READ fill cycle: 0.
- Reset (rst=1 at an edge):
  - state -> IDLE;
  - all valid, tag, data and LRU bits -> 0.
  - Mid-operation reset abandons the SRAM access; sram_read and sram_write are 0 from the next cycle. The pending request is neither completed nor acknowledged.
  - After reset, outputs are sram_read=0, sram_write=0, ready=1 with no request, rdata=0.
- sram_ready seen in IDLE is ignored.

Optional Feature:
- Macro: CACHE_STATS_EN.
- When defined, three ports are added: hit_count out 32, miss_count out 32, stats_clr in 1.
  - hit_count increments once per read hit in IDLE.
  - miss_count increments once per READ entry.
  - Both counters saturate at 32'hFFFF_FFFF.
  - Both clear on rst or stats_clr. Clear wins over increment in the same cycle.
- When not defined, none of the three ports exist and there is no counter logic.

Test Plan:
- After reset, read 0x0000_0040 (default parameters: index 8, offset 0) -> miss, READ entered, sram_read=1 for 3 cycles. sram_ready with sram_rdata=64'hBBBB_BBBB_AAAA_AAAA -> ready=1 and rdata=32'hAAAA_AAAA in the same cycle. A re-read of 0x44 hits in 0 cycles with rdata=32'hBBBB_BBBB.
- Fill 0x040, 0x240 and 0x440 (same set, different tags) -> 0x040 is evicted. Re-read 0x240 before the third fill -> 0x240 survives and 0x040 is the victim.
- Store 32'h1234_5678 to resident 0x044 -> sram_write held until sram_ready. Then read 0x044 -> hit, rdata=32'h1234_5678, no SRAM read.
- Store to non-resident 0x800 -> SRAM write completes; a following read of 0x800 misses (no allocate).
- flush pulsed together with MEM_R_EN to resident 0x040 -> ready=0 that cycle. Next cycle the same read misses.
- rst asserted on the second cycle of READ -> sram_read=0 next cycle, ready=1. A read of the previously resident 0x044 misses.
- With CACHE_STATS_EN: 2 hits + 1 miss -> hit_count=2, miss_count=1. stats_clr -> both 0.
